fsmotor_step_ctl: RTL and testbench
===================================

# fsmotor_step_ctl

Per-channel stepper-motor sequencer that turns a move command into the enable/reset/microstep/drive/direction signal set consumed by one motor slot of the motor-routing block (s0..s5). It supports a counted relative move and a homing move that runs until the channel's zero-position detector (zpd) asserts. It tracks absolute position and reports busy, done and home-timeout status to the processor-side register block.

## Interface
- C_MICROSTEP_WIDTH, 3: microstep select width; matches the motor-routing block.
- C_STEP_NUMBER_WIDTH, 16: width of the step count and of the position counter.
- C_SPEED_DATA_WIDTH, 16: width of the half-period in clk cycles.
- C_DIR_SETUP, 4: clk cycles that dir must be stable before the first drive edge; must be ≥1.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command strobe; accepted only in IDLE.
- cmd_home  in  1  1 = homing move, 0 = counted move.
- cmd_dir  in  1  move direction; 1 = increasing position.
- cmd_steps  in  C_STEP_NUMBER_WIDTH  step count (counted move) or step limit (home).
- cmd_speed  in  C_SPEED_DATA_WIDTH  half-period in cycles; 0 is treated as 1.
- cmd_ms  in  C_MICROSTEP_WIDTH  microstep setting for the move.
- cmd_stop  in  1  abort request; honored in any state.
- en  in  1  channel enable; drives xen directly.
- m_zpd  in  1  zero-position detect from the motor; asynchronous.
- m_xen, m_xrst, m_drive, m_dir  out  1  motor controls.
- m_ms  out  C_MICROSTEP_WIDTH  microstep select.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse at the end of any move.
- home_err  out  1  sticky; set when homing exhausts its step limit; cleared by the next accepted cmd_valid.
- position  out  C_STEP_NUMBER_WIDTH  absolute step position; wraps modulo 2^W.

## Operation
- Reset values:
  - m_xen = 0, m_xrst = 0 (driver held in reset), m_drive = 0, m_dir = 0, m_ms = 0.
  - busy = 0, done = 0, home_err = 0, position = 0.
- m_xrst is released (driven to 1) on the first clk after reset deasserts and stays 1 afterwards.
- m_xen = en, registered (1-cycle delay).
- m_zpd passes through a 2-flop synchronizer. zpd_s is the synchronized value.
- States:
  - IDLE: cmd_valid latches dir, steps, speed, ms and home, then goes to SETUP.
    - Counted move with cmd_steps = 0: no SETUP; done pulses the next cycle.
    - Homing move with zpd_s = 1 already: no SETUP; position = 0 and done pulses the next cycle.
  - SETUP: m_dir and m_ms update on entry. Wait C_DIR_SETUP cycles, then go to HIGH.
  - HIGH: m_drive = 1 for speed cycles.
    - At the rising edge, position increments (dir = 1) or decrements (dir = 0), and the remaining-step counter decrements.
    - Then go to LOW.
  - LOW: m_drive = 0 for speed cycles, then:
    - Counted move: go to HIGH if remaining > 0, else to DONE.
    - Homing move: zpd_s = 1 goes to DONE with position cleared to 0. Remaining = 0 with zpd_s = 0 sets home_err and goes to DONE.
  - DONE: done = 1 for one cycle, then go to IDLE.
- During homing, zpd_s is sampled every cycle in HIGH and LOW. On a hit, the current pulse completes its LOW phase before DONE.
- cmd_stop in SETUP, HIGH or LOW goes to DONE on the next cycle:
  - m_drive is forced to 0 and position keeps the steps already issued.
  - In IDLE, cmd_stop is ignored.
- cmd_valid outside IDLE is ignored. cmd_stop and cmd_valid together in IDLE: stop wins and no move starts.
- Reset mid-move returns all outputs to their reset values immediately, with no finishing pulse.

## Timing
- Counted move latency, from the cmd_valid cycle to the first m_drive rise: 1 + C_DIR_SETUP cycles.
- Step period = 2 × max(speed, 1) cycles. Total counted-move duration = 1 + C_DIR_SETUP + 2·steps·speed, then 1 cycle of DONE.
- zpd reaction time: 2 synchronizer cycles plus the remainder of the current pulse.
- position updates in the same cycle m_drive rises, so it is visible the following cycle.
- The phase counter is C_SPEED_DATA_WIDTH bits and reloads at each phase change. The step counter is C_STEP_NUMBER_WIDTH bits and saturates at 0.

## Structure
- Shared package fsmotor_pkg holds:
  - the state enum (IDLE, SETUP, HIGH, LOW, DONE)
  - default widths
  - the C_DIR_SETUP default
- One natural sub-module: fsmotor_sync2, a 2-flop synchronizer used for zpd and reusable for the other channels.
- Six instances of this block feed the s0..s5 inputs of the motor-routing block.

## Test plan
- Counted move (steps = 3, speed = 2, dir = 1, C_DIR_SETUP = 4):
  - first m_drive rise 5 cycles after cmd_valid
  - 3 pulses, each 2 cycles high and 2 cycles low
  - done pulses once; position 0 → 3; busy is high for exactly 18 cycles.
- Reverse move (steps = 2, dir = 0) from position 3: position = 1; m_dir = 0 at least 4 cycles before the first drive rise.
- Home (steps = 100, speed = 1) with zpd asserted after the 10th pulse: motion stops within 2 pulses, position = 0, home_err = 0.
- Home with zpd never asserted (steps = 5): exactly 5 pulses, home_err = 1. The next cmd_valid clears home_err.
- Abort: cmd_stop during the 2nd HIGH phase of a steps = 10 move gives m_drive = 0 the next cycle, then done, and position = start + 2.
- Edge cases:
  - steps = 0: done after 1 cycle and no pulses.
  - speed = 0: behaves as speed = 1.
  - cmd_valid while busy: ignored.
  - Async reset mid-move: all outputs at reset values immediately.

Source files
------------

// File: rtl/fsmotor_pkg.sv
// Shared types and default sizing for the stepper-motor channel sequencer.
// Every channel instance and the zpd synchronizer pull their defaults from here.
package fsmotor_pkg;

   localparam int MS_W_DEF       = 3;
   localparam int STEP_W_DEF     = 16;
   localparam int SPEED_W_DEF    = 16;
   localparam int DIR_SETUP_DEF  = 4;
   localparam int SYNC_STAGES    = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_HIGH,
      ST_LOW,
      ST_DONE
   } state_e;

endpackage

// File: rtl/fsmotor_sync2.sv
// Two-flop synchronizer for a single asynchronous level input (zpd and similar).
// Reset value is 0 so a detector that is still settling reads as "not home".
module fsmotor_sync2
   import fsmotor_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic d_i,
   output logic q_o
);

   logic [SYNC_STAGES-1:0] sr_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sr_q <= '0;
      end else begin
         sr_q <= {sr_q[SYNC_STAGES-2:0], d_i};
      end
   end

   assign q_o = sr_q[SYNC_STAGES-1];

endmodule

// File: rtl/fsmotor_step_ctl.sv
// One stepper channel: turns counted or homing move commands into
// dir/ms/drive pulses, tracks absolute position and reports busy/done/home_err.
module fsmotor_step_ctl
   import fsmotor_pkg::*;
#(
   parameter int C_MICROSTEP_WIDTH   = MS_W_DEF,
   parameter int C_STEP_NUMBER_WIDTH = STEP_W_DEF,
   parameter int C_SPEED_DATA_WIDTH  = SPEED_W_DEF,
   parameter int C_DIR_SETUP         = DIR_SETUP_DEF
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           cmd_valid,
   input  logic                           cmd_home,
   input  logic                           cmd_dir,
   input  logic [C_STEP_NUMBER_WIDTH-1:0] cmd_steps,
   input  logic [C_SPEED_DATA_WIDTH-1:0]  cmd_speed,
   input  logic [C_MICROSTEP_WIDTH-1:0]   cmd_ms,
   input  logic                           cmd_stop,
   input  logic                           en,
   input  logic                           m_zpd,
   output logic                           m_xen,
   output logic                           m_xrst,
   output logic                           m_drive,
   output logic                           m_dir,
   output logic [C_MICROSTEP_WIDTH-1:0]   m_ms,
   output logic                           busy,
   output logic                           done,
   output logic                           home_err,
   output logic [C_STEP_NUMBER_WIDTH-1:0] position
);

   localparam int SW      = C_STEP_NUMBER_WIDTH;
   localparam int PW      = C_SPEED_DATA_WIDTH;
   localparam int SETUP_W = $clog2(C_DIR_SETUP + 1);

   state_e                  state_q;
   logic                    home_q;
   logic                    hit_q;
   logic                    dir_q;
   logic [C_MICROSTEP_WIDTH-1:0] ms_q;
   logic [SW-1:0]           rem_q;
   logic [SW-1:0]           pos_q;
   logic [PW-1:0]           speed_m1_q;
   logic [PW-1:0]           phase_q;
   logic [SETUP_W-1:0]      setup_q;
   logic                    drive_q;
   logic                    xen_q;
   logic                    xrst_q;
   logic                    busy_q;
   logic                    done_q;
   logic                    herr_q;

   logic                    zpd_s;
   logic [PW-1:0]           speed_m1_d;
   logic [SW-1:0]           pos_step_d;
   logic [SW-1:0]           rem_dec_d;
   logic                    zpd_seen_d;

   fsmotor_sync2 u_zpd_sync (
      .clk   (clk),
      .reset (reset),
      .d_i   (m_zpd),
      .q_o   (zpd_s)
   );

   // A zero half-period would stall the phase counter, so it runs as one cycle.
   always_comb begin
      speed_m1_d = (cmd_speed == '0) ? '0 : cmd_speed - PW'(1);
      pos_step_d = dir_q ? pos_q + SW'(1) : pos_q - SW'(1);
      rem_dec_d  = (rem_q == '0) ? '0 : rem_q - SW'(1);
      zpd_seen_d = hit_q | zpd_s;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         home_q     <= 1'b0;
         hit_q      <= 1'b0;
         dir_q      <= 1'b0;
         ms_q       <= '0;
         rem_q      <= '0;
         pos_q      <= '0;
         speed_m1_q <= '0;
         phase_q    <= '0;
         setup_q    <= '0;
         drive_q    <= 1'b0;
         xen_q      <= 1'b0;
         xrst_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         herr_q     <= 1'b0;
      end else begin
         xrst_q <= 1'b1;
         xen_q  <= en;
         done_q <= 1'b0;

         case (state_q)
            ST_IDLE: begin
               if (cmd_valid && !cmd_stop) begin
                  herr_q     <= 1'b0;
                  home_q     <= cmd_home;
                  hit_q      <= 1'b0;
                  rem_q      <= cmd_steps;
                  speed_m1_q <= speed_m1_d;
                  busy_q     <= 1'b1;
                  if (cmd_home && zpd_s) begin
                     pos_q   <= '0;
                     done_q  <= 1'b1;
                     state_q <= ST_DONE;
                  end else if (cmd_steps == '0) begin
                     // A homing move with no step budget can never find zpd.
                     herr_q  <= cmd_home;
                     done_q  <= 1'b1;
                     state_q <= ST_DONE;
                  end else begin
                     dir_q   <= cmd_dir;
                     ms_q    <= cmd_ms;
                     setup_q <= SETUP_W'(C_DIR_SETUP);
                     state_q <= ST_SETUP;
                  end
               end
            end

            ST_SETUP: begin
               if (cmd_stop) begin
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end else if (setup_q == '0) begin
                  drive_q <= 1'b1;
                  pos_q   <= pos_step_d;
                  rem_q   <= rem_dec_d;
                  phase_q <= speed_m1_q;
                  state_q <= ST_HIGH;
               end else begin
                  setup_q <= setup_q - SETUP_W'(1);
               end
            end

            ST_HIGH: begin
               if (cmd_stop) begin
                  drive_q <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end else begin
                  if (home_q && zpd_s) begin
                     hit_q <= 1'b1;
                  end
                  if (phase_q == '0) begin
                     drive_q <= 1'b0;
                     phase_q <= speed_m1_q;
                     state_q <= ST_LOW;
                  end else begin
                     phase_q <= phase_q - PW'(1);
                  end
               end
            end

            ST_LOW: begin
               if (cmd_stop) begin
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end else if (phase_q != '0) begin
                  phase_q <= phase_q - PW'(1);
                  if (home_q && zpd_s) begin
                     hit_q <= 1'b1;
                  end
               end else if (home_q && zpd_seen_d) begin
                  pos_q   <= '0;
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end else if (rem_q == '0) begin
                  herr_q  <= home_q;
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end else begin
                  drive_q <= 1'b1;
                  pos_q   <= pos_step_d;
                  rem_q   <= rem_dec_d;
                  phase_q <= speed_m1_q;
                  state_q <= ST_HIGH;
               end
            end

            ST_DONE: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end

            default: begin
               drive_q <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign m_xen    = xen_q;
   assign m_xrst   = xrst_q;
   assign m_drive  = drive_q;
   assign m_dir    = dir_q;
   assign m_ms     = ms_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign home_err = herr_q;
   assign position = pos_q;

endmodule

// File: tb/tb_fsmotor_step_ctl.sv
// Directed bench for fsmotor_step_ctl: each move pushes its expected outcome to a
// scoreboard queue, which is popped and compared when the channel drops busy.
module tb_fsmotor_step_ctl;

   localparam int MSW = 3;
   localparam int SW  = 16;
   localparam int PW  = 16;
   localparam int DS  = 4;

   logic           clk = 1'b0;
   logic           reset;
   logic           cmd_valid;
   logic           cmd_home;
   logic           cmd_dir;
   logic [SW-1:0]  cmd_steps;
   logic [PW-1:0]  cmd_speed;
   logic [MSW-1:0] cmd_ms;
   logic           cmd_stop;
   logic           en;
   logic           m_zpd;
   logic           m_xen;
   logic           m_xrst;
   logic           m_drive;
   logic           m_dir;
   logic [MSW-1:0] m_ms;
   logic           busy;
   logic           done;
   logic           home_err;
   logic [SW-1:0]  position;

   typedef struct {
      logic [SW-1:0] pos;
      int            pmin;
      int            pmax;
      logic          herr;
      int            busy_cyc;
      int            hi_len;
   } exp_t;

   exp_t          sb[$];
   int            checks   = 0;
   int            failures = 0;
   logic [SW-1:0] model_pos;

   fsmotor_step_ctl #(
      .C_MICROSTEP_WIDTH   (MSW),
      .C_STEP_NUMBER_WIDTH (SW),
      .C_SPEED_DATA_WIDTH  (PW),
      .C_DIR_SETUP         (DS)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_home  (cmd_home),
      .cmd_dir   (cmd_dir),
      .cmd_steps (cmd_steps),
      .cmd_speed (cmd_speed),
      .cmd_ms    (cmd_ms),
      .cmd_stop  (cmd_stop),
      .en        (en),
      .m_zpd     (m_zpd),
      .m_xen     (m_xen),
      .m_xrst    (m_xrst),
      .m_drive   (m_drive),
      .m_dir     (m_dir),
      .m_ms      (m_ms),
      .busy      (busy),
      .done      (done),
      .home_err  (home_err),
      .position  (position)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
         $error("check %s did not match", tag);
      end
   endtask

   // Called at a negedge with the channel idle; returns at the negedge where busy is low.
   task automatic run_move(input string name, input logic home, input logic dir,
                           input logic [SW-1:0] steps, input logic [PW-1:0] speed,
                           input logic [MSW-1:0] ms, input int zpd_after,
                           input int stop_at, input bit inject);
      exp_t e;
      exp_t got;
      int   spd, n, cyc, rises, dones, busy_cyc, first_rise, hi_len, dir_ok;
      logic prev_drv;
      bit   stop_chk;

      spd = (speed == '0) ? 1 : int'(speed);
      n   = int'(steps);
      e.herr = 1'b0; e.busy_cyc = 0; e.hi_len = 0;
      if (stop_at > 0) begin
         e.pmin = stop_at; e.pmax = stop_at;
         e.pos  = dir ? model_pos + SW'(stop_at) : model_pos - SW'(stop_at);
      end else if (!home) begin
         e.pmin = n; e.pmax = n;
         e.pos  = dir ? model_pos + steps : model_pos - steps;
         e.busy_cyc = (n == 0) ? 1 : DS + 2 + 2 * n * spd;
         e.hi_len   = (n == 0) ? 0 : spd;
      end else if (zpd_after < 0) begin
         e.pmin = 0; e.pmax = 0; e.pos = '0; e.busy_cyc = 1;
      end else if (zpd_after > 0) begin
         e.pmin = zpd_after; e.pmax = zpd_after + 2; e.pos = '0;
      end else begin
         e.pmin = n; e.pmax = n; e.herr = 1'b1;
         e.pos  = dir ? model_pos + steps : model_pos - steps;
         e.busy_cyc = DS + 2 + 2 * n * spd;
         e.hi_len   = spd;
      end
      sb.push_back(e);

      cmd_home = home; cmd_dir = dir; cmd_steps = steps; cmd_speed = speed;
      cmd_ms = ms; cmd_valid = 1'b1;
      cyc = 0; rises = 0; dones = 0; busy_cyc = 0; first_rise = 0; hi_len = 0;
      dir_ok = 0; prev_drv = m_drive; stop_chk = 1'b0;

      while (1) begin
         @(negedge clk);
         cyc++;
         cmd_valid = 1'b0; cmd_steps = steps; cmd_dir = dir;
         if (cyc == 1) check({name, "_herr_clr"}, home_err, 0);
         if (stop_chk) begin
            check({name, "_stop_drv"}, m_drive, 0);
            check({name, "_stop_done"}, done, 1);
            stop_chk = 1'b0;
            cmd_stop = 1'b0;
         end
         if (busy) busy_cyc++;
         if (done) dones++;
         if (m_drive && !prev_drv) begin
            rises++;
            if (rises == 1) begin
               first_rise = cyc - 1;
               check({name, "_ms"}, m_ms, ms);
               check({name, "_dir_setup"}, (dir_ok >= DS), 1);
            end
            if (rises == zpd_after) m_zpd = 1'b1;
            if (rises == stop_at) begin cmd_stop = 1'b1; stop_chk = 1'b1; end
            if (inject && rises == 1) begin
               cmd_valid = 1'b1; cmd_steps = 50; cmd_dir = ~dir;
            end
         end
         if (rises == 1 && m_drive) hi_len++;
         if (rises == 0) dir_ok = (m_dir === dir) ? dir_ok + 1 : 0;
         prev_drv = m_drive;
         if (!busy) break;
         if (cyc > 5000) begin
            checks++; failures++;
            $display("FAIL %s_timeout observed=busy expected=idle", name);
            break;
         end
      end

      got = sb.pop_front();
      check({name, "_pos"}, position, got.pos);
      if (got.pmin == got.pmax) check({name, "_pulses"}, rises, got.pmin);
      else check({name, "_pulses_in_range"}, (rises >= got.pmin && rises <= got.pmax), 1);
      check({name, "_done_cnt"}, dones, 1);
      check({name, "_herr"}, home_err, got.herr);
      if (got.busy_cyc > 0) check({name, "_busy_cyc"}, busy_cyc, got.busy_cyc);
      if (got.hi_len > 0) begin
         check({name, "_hi_len"}, hi_len, got.hi_len);
         check({name, "_first_rise"}, first_rise, DS + 1);
      end
      model_pos = got.pos;
   endtask

   initial begin
      reset = 1'b1; cmd_valid = 1'b0; cmd_home = 1'b0; cmd_dir = 1'b0;
      cmd_steps = '0; cmd_speed = '0; cmd_ms = '0; cmd_stop = 1'b0;
      en = 1'b0; m_zpd = 1'b0; model_pos = '0;

      repeat (3) @(negedge clk);
      check("reset_outputs", {m_xen, m_xrst, m_drive, m_dir, m_ms, busy, done, home_err, position}, 0);
      reset = 1'b0;
      #1 check("xrst_held", m_xrst, 0);
      en = 1'b1;
      @(negedge clk);
      check("xrst_release", m_xrst, 1);
      check("xen_follow", m_xen, 1);

      run_move("fwd3",    1'b0, 1'b1, 16'd3,   16'd2, 3'd3, 0, 0, 1'b0);
      run_move("rev2",    1'b0, 1'b0, 16'd2,   16'd2, 3'd1, 0, 0, 1'b0);
      run_move("zero",    1'b0, 1'b1, 16'd0,   16'd2, 3'd2, 0, 0, 1'b0);
      run_move("spd0",    1'b0, 1'b1, 16'd2,   16'd0, 3'd5, 0, 0, 1'b0);
      run_move("inject",  1'b0, 1'b1, 16'd3,   16'd1, 3'd4, 0, 0, 1'b1);
      run_move("home_hit",1'b1, 1'b0, 16'd100, 16'd1, 3'd2, 10, 0, 1'b0);
      m_zpd = 1'b0;
      repeat (3) @(negedge clk);
      run_move("home_to", 1'b1, 1'b1, 16'd5,   16'd1, 3'd0, 0, 0, 1'b0);
      @(negedge clk);
      check("herr_sticky", home_err, 1);
      run_move("after_to",1'b0, 1'b1, 16'd2,   16'd1, 3'd6, 0, 0, 1'b0);
      m_zpd = 1'b1;
      repeat (3) @(negedge clk);
      run_move("home_at0",1'b1, 1'b1, 16'd20,  16'd1, 3'd1, -1, 0, 1'b0);
      m_zpd = 1'b0;
      repeat (3) @(negedge clk);
      run_move("abort",   1'b0, 1'b1, 16'd10,  16'd3, 3'd7, 0, 2, 1'b0);

      cmd_valid = 1'b1; cmd_stop = 1'b1; cmd_home = 1'b0; cmd_steps = 16'd4; cmd_speed = 16'd1;
      @(negedge clk);
      cmd_valid = 1'b0; cmd_stop = 1'b0;
      check("stop_valid_busy", busy, 0);
      @(negedge clk);
      check("stop_valid_idle", {busy, done}, 0);
      check("stop_valid_pos", position, model_pos);

      cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 16'd10; cmd_speed = 16'd2;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (8) @(negedge clk);
      check("midmove_active", busy, 1);
      reset = 1'b1;
      #1 check("midmove_reset", {m_xen, m_xrst, m_drive, m_dir, m_ms, busy, done, home_err, position}, 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
